// File: rtl/btc_feeder_pkg.sv
// Shared definitions for the bit-serial tensor core operand feeder:
// beat kinds, FSM states, per-kind beat layout and group bitmaps.
package btc_feeder_pkg;

  localparam int BEAT_W     = 256;
  localparam int NUM_SLOTS  = 16;
  localparam int SHIFT_HI_W = 128;

  typedef enum logic [2:0] {
    KIND_WDATA  = 3'd0,
    KIND_WSIGN  = 3'd1,
    KIND_WSEL0  = 3'd2,
    KIND_WSEL1  = 3'd3,
    KIND_SHIFT  = 3'd4,
    KIND_ACT    = 3'd5,
    KIND_PSUM   = 3'd6,
    KIND_COMMIT = 3'd7
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam int BEATS_WDATA = 4;
  localparam int BEATS_WSIGN = 1;
  localparam int BEATS_WSEL0 = 1;
  localparam int BEATS_WSEL1 = 2;
  localparam int BEATS_SHIFT = 2;
  localparam int BEATS_ACT   = 4;
  localparam int BEATS_PSUM  = 2;

  localparam int OFS_WDATA = 0;
  localparam int OFS_WSIGN = 4;
  localparam int OFS_WSEL0 = 5;
  localparam int OFS_WSEL1 = 6;
  localparam int OFS_SHIFT = 8;
  localparam int OFS_ACT   = 10;
  localparam int OFS_PSUM  = 14;

  localparam logic [NUM_SLOTS-1:0] GRP_WEIGHT = 16'h03FF;
  localparam logic [NUM_SLOTS-1:0] GRP_ACT    = 16'h3C00;
  localparam logic [NUM_SLOTS-1:0] GRP_PSUM   = 16'hC000;

  function automatic logic [2:0] beatCount(input kind_e k);
    case (k)
      KIND_WDATA: return 3'(BEATS_WDATA);
      KIND_WSIGN: return 3'(BEATS_WSIGN);
      KIND_WSEL0: return 3'(BEATS_WSEL0);
      KIND_WSEL1: return 3'(BEATS_WSEL1);
      KIND_SHIFT: return 3'(BEATS_SHIFT);
      KIND_ACT:   return 3'(BEATS_ACT);
      KIND_PSUM:  return 3'(BEATS_PSUM);
      default:    return 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] slotOffset(input kind_e k);
    case (k)
      KIND_WDATA: return 4'(OFS_WDATA);
      KIND_WSIGN: return 4'(OFS_WSIGN);
      KIND_WSEL0: return 4'(OFS_WSEL0);
      KIND_WSEL1: return 4'(OFS_WSEL1);
      KIND_SHIFT: return 4'(OFS_SHIFT);
      KIND_ACT:   return 4'(OFS_ACT);
      KIND_PSUM:  return 4'(OFS_PSUM);
      default:    return 4'd0;
    endcase
  endfunction

  // Commit mask is {psum, act, weight}; expand it to the bitmap slots it covers.
  function automatic logic [NUM_SLOTS-1:0] groupSlots(input logic [2:0] m);
    return (m[0] ? GRP_WEIGHT : '0) | (m[1] ? GRP_ACT : '0) | (m[2] ? GRP_PSUM : '0);
  endfunction

endpackage

// File: rtl/btc_operand_feeder.sv
// Operand feeder: assembles 256-bit beats into staging slots and, on COMMIT,
// copies the selected groups into the live tensor-core inputs with update strobes.
module btc_operand_feeder
  import btc_feeder_pkg::*;
#(
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [1:0]        in_idx,
  input  logic [BEAT_W-1:0] in_data,
  input  logic              clr_err,
  output logic [1023:0]     weight_data_in,
  output logic [255:0]      weight_sign_in,
  output logic [255:0]      weight_sel_level0,
  output logic [511:0]      weight_sel_level1,
  output logic [383:0]      shift_offset,
  output logic [1023:0]     activation_in,
  output logic [511:0]      psum_data_in,
  output logic              weight_update,
  output logic              activation_update,
  output logic              psum_update,
  output logic              busy,
  output logic              err_incomplete,
  output logic              err_addr
);

  localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  state_e                 r_state;
  state_e                 w_nextState;
  logic [CNT_W-1:0]       r_holdCnt;
  logic                   r_readyEn;
  logic [2:0]             r_pendMask;
  logic [NUM_SLOTS-1:0]   r_written;
  logic [BEAT_W-1:0]      r_stage [NUM_SLOTS];

  kind_e                  w_kind;
  logic                   w_accept;
  logic                   w_isData;
  logic                   w_idxOk;
  logic                   w_commitGo;
  logic                   w_issue;
  logic                   w_incomplete;
  logic [3:0]             w_slot;
  logic [NUM_SLOTS-1:0]   w_setBits;
  logic [NUM_SLOTS-1:0]   w_grpBits;
  logic [NUM_SLOTS-1:0]   w_clrBits;

  assign w_kind     = kind_e'(in_kind);
  assign w_accept   = in_valid && in_ready;
  assign w_isData   = w_accept && (w_kind != KIND_COMMIT);
  assign w_idxOk    = ({1'b0, in_idx} < beatCount(w_kind));
  assign w_slot     = slotOffset(w_kind) + {2'b00, in_idx};
  assign w_setBits  = (w_isData && w_idxOk) ? (16'h0001 << w_slot) : '0;
  assign w_commitGo = w_accept && (w_kind == KIND_COMMIT) && (in_data[2:0] != 3'b000);
  assign w_issue    = (r_state == ST_ISSUE);
  assign w_grpBits  = groupSlots(r_pendMask);
  assign w_clrBits  = w_issue ? w_grpBits : '0;
  assign w_incomplete = w_issue && ((r_written & w_grpBits) != w_grpBits);

  // r_readyEn holds in_ready low until the first edge after reset release.
  assign in_ready = r_readyEn && (r_state == ST_IDLE);
  assign busy     = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_readyEn  <= 1'b0;
      r_pendMask <= 3'b000;
      r_holdCnt  <= '0;
    end else begin
      r_state   <= w_nextState;
      r_readyEn <= 1'b1;
      if (w_commitGo) r_pendMask <= in_data[2:0];
      if (w_issue) r_holdCnt <= CNT_W'(HOLD_CYCLES);
      else if ((r_state == ST_HOLD) && (r_holdCnt != '0)) r_holdCnt <= r_holdCnt - CNT_W'(1);
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (w_commitGo) w_nextState = ST_ISSUE;
      ST_ISSUE: w_nextState = (HOLD_CYCLES > 0) ? ST_HOLD : ST_IDLE;
      ST_HOLD:  if (r_holdCnt <= CNT_W'(1)) w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  // One staging slot per bitmap bit; SHIFT beat 1 only ever exposes its low 128 bits.
  for (genvar b = 0; b < NUM_SLOTS; b++) begin : gStage
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_stage[b] <= '0;
      else if (w_setBits[b]) r_stage[b] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_written         <= '0;
      err_addr          <= 1'b0;
      err_incomplete    <= 1'b0;
      weight_update     <= 1'b0;
      activation_update <= 1'b0;
      psum_update       <= 1'b0;
    end else begin
      r_written         <= (r_written & ~w_clrBits) | w_setBits;
      err_addr          <= (w_isData && !w_idxOk) || (err_addr && !clr_err);
      err_incomplete    <= w_incomplete || (err_incomplete && !clr_err);
      weight_update     <= w_issue && r_pendMask[0];
      activation_update <= w_issue && r_pendMask[1];
      psum_update       <= w_issue && r_pendMask[2];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      weight_data_in    <= '0;
      weight_sign_in    <= '0;
      weight_sel_level0 <= '0;
      weight_sel_level1 <= '0;
      shift_offset      <= '0;
    end else if (w_issue && r_pendMask[0]) begin
      weight_data_in    <= {r_stage[OFS_WDATA+3], r_stage[OFS_WDATA+2],
                            r_stage[OFS_WDATA+1], r_stage[OFS_WDATA]};
      weight_sign_in    <= r_stage[OFS_WSIGN];
      weight_sel_level0 <= r_stage[OFS_WSEL0];
      weight_sel_level1 <= {r_stage[OFS_WSEL1+1], r_stage[OFS_WSEL1]};
      shift_offset      <= {r_stage[OFS_SHIFT+1][SHIFT_HI_W-1:0], r_stage[OFS_SHIFT]};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      activation_in <= '0;
    end else if (w_issue && r_pendMask[1]) begin
      activation_in <= {r_stage[OFS_ACT+3], r_stage[OFS_ACT+2],
                        r_stage[OFS_ACT+1], r_stage[OFS_ACT]};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      psum_data_in <= '0;
    end else if (w_issue && r_pendMask[2]) begin
      psum_data_in <= {r_stage[OFS_PSUM+1], r_stage[OFS_PSUM]};
    end
  end

endmodule

// File: tb/tb_btc_operand_feeder.sv
// Self-checking bench for btc_operand_feeder: directed scenarios plus random
// beats, with strobe events checked against a queue of expected commits.
module tb_btc_operand_feeder;

  localparam int HOLD = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_kind = '0;
  logic [1:0]    in_idx = '0;
  logic [255:0]  in_data = '0;
  logic          clr_err = 1'b0;
  logic [1023:0] weight_data_in;
  logic [255:0]  weight_sign_in;
  logic [255:0]  weight_sel_level0;
  logic [511:0]  weight_sel_level1;
  logic [383:0]  shift_offset;
  logic [1023:0] activation_in;
  logic [511:0]  psum_data_in;
  logic          weight_update;
  logic          activation_update;
  logic          psum_update;
  logic          busy;
  logic          err_incomplete;
  logic          err_addr;

  btc_operand_feeder #(.HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_idx(in_idx), .in_data(in_data), .clr_err(clr_err),
    .weight_data_in(weight_data_in), .weight_sign_in(weight_sign_in),
    .weight_sel_level0(weight_sel_level0), .weight_sel_level1(weight_sel_level1),
    .shift_offset(shift_offset), .activation_in(activation_in),
    .psum_data_in(psum_data_in), .weight_update(weight_update),
    .activation_update(activation_update), .psum_update(psum_update),
    .busy(busy), .err_incomplete(err_incomplete), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // Reference model: staging beats per kind, written flags, live values, flags.
  int            kBeats [7] = '{4, 1, 1, 2, 2, 4, 2};
  logic [255:0]  mStage [7][4];
  bit            mWritten [7][4];
  logic [1023:0] mWd, mAct;
  logic [255:0]  mWs, mS0;
  logic [511:0]  mS1, mPs;
  logic [383:0]  mSh;
  bit            mErrInc, mErrAddr;

  typedef struct {
    logic [2:0]    mask;
    logic [1023:0] wd;
    logic [255:0]  ws;
    logic [255:0]  s0;
    logic [511:0]  s1;
    logic [383:0]  sh;
    logic [1023:0] act;
    logic [511:0]  ps;
    bit            errInc;
    int            cyc;
  } expItem_t;

  expItem_t expQ[$];

  function automatic void checkOutput(string name, logic [1023:0] act, logic [1023:0] exp);
    int first;
    checks++;
    if (act !== exp) begin
      errors++;
      first = 0;
      for (int w = 31; w >= 0; w--) if (act[32*w +: 32] !== exp[32*w +: 32]) first = w;
      $display("[TB] FAIL %s word %0d got %h want %h (t=%0t)", name, first,
               act[32*first +: 32], exp[32*first +: 32], $time);
    end
  endfunction

  function automatic void modelReset();
    for (int k = 0; k < 7; k++)
      for (int i = 0; i < 4; i++) begin
        mStage[k][i]   = '0;
        mWritten[k][i] = 1'b0;
      end
    mWd = '0; mWs = '0; mS0 = '0; mS1 = '0; mSh = '0; mAct = '0; mPs = '0;
    mErrInc = 1'b0; mErrAddr = 1'b0;
    expQ.delete();
  endfunction

  function automatic bit groupIncomplete(int kLo, int kHi);
    bit inc = 1'b0;
    for (int k = kLo; k <= kHi; k++)
      for (int i = 0; i < kBeats[k]; i++) begin
        if (!mWritten[k][i]) inc = 1'b1;
        mWritten[k][i] = 1'b0;
      end
    return inc;
  endfunction

  function automatic void modelCommit(logic [2:0] mask, int cyc);
    expItem_t it;
    bit inc = 1'b0;
    if (mask[0]) begin
      inc |= groupIncomplete(0, 4);
      mWd = {mStage[0][3], mStage[0][2], mStage[0][1], mStage[0][0]};
      mWs = mStage[1][0];
      mS0 = mStage[2][0];
      mS1 = {mStage[3][1], mStage[3][0]};
      mSh = {mStage[4][1][127:0], mStage[4][0]};
    end
    if (mask[1]) begin
      inc |= groupIncomplete(5, 5);
      mAct = {mStage[5][3], mStage[5][2], mStage[5][1], mStage[5][0]};
    end
    if (mask[2]) begin
      inc |= groupIncomplete(6, 6);
      mPs = {mStage[6][1], mStage[6][0]};
    end
    mErrInc |= inc;
    it.mask = mask; it.wd = mWd; it.ws = mWs; it.s0 = mS0; it.s1 = mS1;
    it.sh = mSh; it.act = mAct; it.ps = mPs; it.errInc = mErrInc; it.cyc = cyc;
    expQ.push_back(it);
  endfunction

  function automatic logic [255:0] randBeat();
    logic [255:0] v;
    for (int w = 0; w < 8; w++) v[32*w +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [255:0] patBeat(int k, int i);
    logic [7:0] b;
    b = 8'(k * 16 + i);
    return {32{b}};
  endfunction

  // Drive one beat, wait (bounded) for acceptance, then update the model.
  task automatic applyStimulus(input int kind, input int idx, input logic [255:0] data, input bit clr);
    int waitCnt = 0;
    bit newAddr = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_kind = 3'(kind); in_idx = 2'(idx); in_data = data; clr_err = clr;
    while (!in_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("[TB] FAIL accept_timeout got in_ready=0 want 1 (t=%0t)", $time);
      in_valid = 1'b0; clr_err = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; clr_err = 1'b0;
    if (kind == 7) begin
      if (data[2:0] != 3'b000) modelCommit(data[2:0], cycle);
    end else if (idx < kBeats[kind]) begin
      mStage[kind][idx]   = (kind == 4 && idx == 1) ? {128'b0, data[127:0]} : data;
      mWritten[kind][idx] = 1'b1;
    end else begin
      newAddr = 1'b1;
    end
    mErrAddr = newAddr | (mErrAddr & !clr);
    if (clr) mErrInc = 1'b0;
    checkOutput("err_addr", 1024'(err_addr), 1024'(mErrAddr));
  endtask

  task automatic measureReadyLow(input int expected);
    int low = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n == 0) checkOutput("busy_after_commit", 1024'(busy), 1024'(1));
      if (in_ready) break;
      low++;
    end
    checkOutput("ready_low_cycles", 1024'(low), 1024'(expected));
  endtask

  task automatic pulseClr();
    @(negedge clk);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    mErrAddr = 1'b0;
    mErrInc  = 1'b0;
    checkOutput("err_cleared", 1024'({err_addr, err_incomplete}), 1024'(0));
  endtask

  task automatic checkAllZero(string name);
    logic anyHigh;
    anyHigh = |{weight_data_in, weight_sign_in, weight_sel_level0, weight_sel_level1,
                shift_offset, activation_in, psum_data_in, weight_update,
                activation_update, psum_update, busy, err_incomplete, err_addr, in_ready};
    checkOutput(name, 1024'(anyHigh), 1024'(0));
  endtask

  // Monitor: every strobe event must match the oldest expected commit.
  always @(negedge clk) begin
    expItem_t it;
    if (rstn === 1'b1 && (weight_update || activation_update || psum_update)) begin
      if (expQ.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_strobe got %b want none (t=%0t)",
                 {psum_update, activation_update, weight_update}, $time);
      end else begin
        it = expQ.pop_front();
        checkOutput("strobe_mask", 1024'({psum_update, activation_update, weight_update}), 1024'(it.mask));
        checkOutput("strobe_cycle", 1024'(cycle), 1024'(it.cyc + 1));
        checkOutput("weight_data_in", weight_data_in, it.wd);
        checkOutput("weight_sign_in", 1024'(weight_sign_in), 1024'(it.ws));
        checkOutput("weight_sel_level0", 1024'(weight_sel_level0), 1024'(it.s0));
        checkOutput("weight_sel_level1", 1024'(weight_sel_level1), 1024'(it.s1));
        checkOutput("shift_offset", 1024'(shift_offset), 1024'(it.sh));
        checkOutput("activation_in", activation_in, it.act);
        checkOutput("psum_data_in", 1024'(psum_data_in), 1024'(it.ps));
        checkOutput("err_incomplete", 1024'(err_incomplete), 1024'(it.errInc));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    #1;
    checkAllZero("reset_outputs");
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    #1;
    checkOutput("ready_before_first_edge", 1024'(in_ready), 1024'(0));
    @(posedge clk);
    #1;
    checkOutput("ready_after_first_edge", 1024'(in_ready), 1024'(1));

    // Full weight group with patterned beats.
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < kBeats[k]; i++) applyStimulus(k, i, patBeat(k, i), 1'b0);
    applyStimulus(7, 0, 256'd1, 1'b0);
    measureReadyLow(1 + HOLD);
    checkOutput("wdata_low_beat", 1024'(weight_data_in[255:0]), 1024'({32{8'h00}}));
    checkOutput("wdata_high_beat", 1024'(weight_data_in[1023:768]), 1024'({32{8'h03}}));
    checkOutput("complete_no_err", 1024'(err_incomplete), 1024'(0));

    // SHIFT beat 1 only touches the upper 128 bits.
    applyStimulus(4, 1, {256{1'b1}}, 1'b0);
    applyStimulus(7, 0, 256'd1, 1'b0);
    measureReadyLow(1 + HOLD);
    checkOutput("shift_hi_ones", 1024'(shift_offset[383:256]), 1024'({128{1'b1}}));
    checkOutput("shift_lo_kept", 1024'(shift_offset[255:0]), 1024'({32{8'h40}}));
    checkOutput("weight_recommit_incomplete", 1024'(err_incomplete), 1024'(1));
    pulseClr();

    // Partial activation group.
    for (int i = 0; i < 3; i++) applyStimulus(5, i, randBeat(), 1'b0);
    applyStimulus(7, 0, 256'd2, 1'b0);
    measureReadyLow(1 + HOLD);
    checkOutput("act_incomplete", 1024'(err_incomplete), 1024'(1));
    pulseClr();

    // Address errors, including clear colliding with a new error.
    applyStimulus(1, 3, randBeat(), 1'b0);
    checkOutput("wsign_unchanged", 1024'(weight_sign_in), 1024'({32{8'h10}}));
    pulseClr();
    applyStimulus(6, 3, randBeat(), 1'b1);
    checkOutput("err_addr_wins_clear", 1024'(err_addr), 1024'(1));
    pulseClr();

    // Random beats and commits.
    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = int'($urandom_range(0, 7));
      if (kind == 7) applyStimulus(7, 0, 256'($urandom_range(0, 7)), 1'b0);
      else applyStimulus(kind, int'($urandom_range(0, 3)), randBeat(), 1'b0);
    end

    // Every group fully written, then a commit of all three.
    for (int k = 0; k < 7; k++)
      for (int i = 0; i < kBeats[k]; i++) applyStimulus(k, i, randBeat(), 1'b0);
    applyStimulus(7, 0, 256'd7, 1'b0);
    measureReadyLow(1 + HOLD);
    applyStimulus(7, 0, 256'd0, 1'b0);
    checkOutput("mask0_ready", 1024'(in_ready), 1024'(1));
    @(negedge clk);
    checkOutput("mask0_no_strobe", 1024'({psum_update, activation_update, weight_update, busy}), 1024'(0));

    // Reset in HOLD, then commit with nothing written.
    applyStimulus(7, 0, 256'd1, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("busy_in_hold", 1024'(busy), 1024'(1));
    rstn = 1'b0;
    #1;
    checkAllZero("reset_in_hold_outputs");
    modelReset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ready_after_rerelease", 1024'(in_ready), 1024'(1));
    applyStimulus(7, 0, 256'd7, 1'b0);
    measureReadyLow(1 + HOLD);

    repeat (10) @(negedge clk);
    checkOutput("scoreboard_drained", 1024'(expQ.size()), 1024'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
